// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that shares one JK register bank among several requesters.
// A granted requester may lock the bank across consecutive cycles.
module jk_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input  logic                  Clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] j_in,
  input  logic [NREQ*WIDTH-1:0] k_in,
  output logic [NREQ-1:0]       gnt,
  output logic [IDW-1:0]        gnt_id,
  output logic                  locked,
  output logic [IDW-1:0]        lock_owner,
  output logic [WIDTH-1:0]      q
);

  typedef enum logic [0:0] {StArb, StLocked} state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   owner_q;
  logic [WIDTH-1:0] bank_q;

  logic [NREQ-1:0]  gnt_c;
  logic [IDW-1:0]   id_c;
  logic             found;
  logic [IDW-1:0]   idx;
  logic [WIDTH-1:0] j_sel;
  logic [WIDTH-1:0] k_sel;
  logic [WIDTH-1:0] bank_jk;
  logic [IDW-1:0]   ptr_after_gnt;
  logic [IDW-1:0]   ptr_after_owner;

  // Grant search starts at ptr and wraps; a lock restricts it to the owner.
  always_comb begin
    gnt_c = '0;
    id_c  = '0;
    found = 1'b0;
    idx   = '0;
    if (state_q == StArb) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = IDW'((32'(ptr_q) + k) % NREQ);
        if (!found && req[idx]) begin
          found       = 1'b1;
          gnt_c[idx]  = 1'b1;
          id_c        = idx;
        end
      end
    end else if (req[owner_q]) begin
      gnt_c[owner_q] = 1'b1;
      id_c           = owner_q;
    end
    if (!rst) begin
      gnt_c = '0;
      id_c  = '0;
    end
  end

  always_comb begin
    j_sel           = j_in[32'(id_c)*WIDTH +: WIDTH];
    k_sel           = k_in[32'(id_c)*WIDTH +: WIDTH];
    bank_jk         = (j_sel & ~bank_q) | (~k_sel & bank_q);
    ptr_after_gnt   = IDW'((32'(id_c) + 1) % NREQ);
    ptr_after_owner = IDW'((32'(owner_q) + 1) % NREQ);
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_q <= StArb;
      ptr_q   <= '0;
      owner_q <= '0;
      bank_q  <= '0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (|gnt_c) begin
            bank_q <= bank_jk;
            if (lock[id_c]) begin
              state_q <= StLocked;
              owner_q <= id_c;
            end else begin
              ptr_q <= ptr_after_gnt;
            end
          end
        end
        StLocked: begin
          if (req[owner_q]) begin
            bank_q <= bank_jk;
          end
          // Releasing by dropping req or lock both hand the pointer past the owner.
          if (!req[owner_q] || !lock[owner_q]) begin
            state_q <= StArb;
            ptr_q   <= ptr_after_owner;
            owner_q <= '0;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

  assign gnt        = gnt_c;
  assign gnt_id     = id_c;
  assign locked     = (state_q == StLocked);
  assign lock_owner = owner_q;
  assign q          = bank_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed and random bench for jk_bank_arbiter against a behavioural bank/arbiter model.
module tb_jk_bank_arbiter;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDW   = 2;

  logic                  Clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] j_in;
  logic [NREQ*WIDTH-1:0] k_in;
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        gnt_id;
  logic                  locked;
  logic [IDW-1:0]        lock_owner;
  logic [WIDTH-1:0]      q;

  jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .Clk        (Clk),
    .rst        (rst),
    .req        (req),
    .lock       (lock),
    .j_in       (j_in),
    .k_in       (k_in),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .locked     (locked),
    .lock_owner (lock_owner),
    .q          (q)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_ptr;
  bit          m_locked;
  int          m_owner;
  logic [7:0]  m_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_gid();
    int g = -1;
    if (m_locked) begin
      if (req[m_owner]) g = m_owner;
    end else begin
      for (int off = 0; off < NREQ; off++) begin
        int i = (m_ptr + off) % NREQ;
        if (g < 0 && req[i]) g = i;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_locked = 0; m_owner = 0; m_q = 8'h00;
  endtask

  // Drive one cycle: check combinational/registered outputs, clock, update model.
  task automatic step(input logic [3:0] r, input logic [3:0] l,
                      input logic [31:0] jv, input logic [31:0] kv);
    int g;
    logic [7:0] js, ks;
    req = r; lock = l; j_in = jv; k_in = kv;
    #1;
    g = model_gid();
    check("gnt", 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
    check("gnt_id", 32'(gnt_id), (g >= 0) ? 32'(g) : 32'd0);
    check("locked", 32'(locked), 32'(m_locked));
    check("lock_owner", 32'(lock_owner), m_locked ? 32'(m_owner) : 32'd0);
    check("q", 32'(q), 32'(m_q));
    @(posedge Clk);
    if (g >= 0) begin
      js = jv[g*8 +: 8];
      ks = kv[g*8 +: 8];
      for (int b = 0; b < 8; b++) begin
        case ({js[b], ks[b]})
          2'b10: m_q[b] = 1'b1;
          2'b01: m_q[b] = 1'b0;
          2'b11: m_q[b] = ~m_q[b];
          default: ;
        endcase
      end
    end
    if (m_locked) begin
      if (g < 0 || !l[m_owner]) begin
        m_locked = 0; m_ptr = (m_owner + 1) % NREQ; m_owner = 0;
      end
    end else if (g >= 0) begin
      if (l[g]) begin m_locked = 1; m_owner = g; end
      else m_ptr = (g + 1) % NREQ;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; lock = '0;
    @(posedge Clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    rst = 1'b0; req = 4'b1111; lock = '0; j_in = '0; k_in = '0;
    // 1: reset forces grant off
    #3;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    @(posedge Clk); #1;
    rst = 1'b1; #1;
    check("post_rst_gnt", 32'(gnt), 32'd1);
    check("post_rst_gnt_id", 32'(gnt_id), 32'd0);

    // 2: set then toggle through requester 2
    do_reset();
    step(4'b0100, 4'b0000, 32'h00F0_0000, 32'h0000_0000);
    check("t2_set", 32'(q), 32'hF0);
    step(4'b0100, 4'b0000, 32'h00FF_0000, 32'h00FF_0000);
    check("t2_toggle", 32'(q), 32'h0F);

    // 3: plain rotation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      #1;
      req = 4'b1111;
      #1;
      check("t3_seq", 32'(gnt_id), 32'(i % 4));
      step(4'b1111, 4'b0000, $urandom, $urandom);
    end

    // 4: lock by requester 1, then release
    do_reset();
    step(4'b0011, 4'b0000, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, 4'b0010, 32'h0000_0100 << i, 32'h0);
      check("t4_locked", 32'(locked), 32'd1);
      check("t4_owner", 32'(lock_owner), 32'd1);
    end
    req = 4'b0011; lock = 4'b0000; #1;
    check("t4_gnt_held", 32'(gnt), 32'b0010);
    step(4'b0011, 4'b0000, 32'h0, 32'h0);
    check("t4_unlocked", 32'(locked), 32'd0);
    req = 4'b0011; #1;
    check("t4_wrap", 32'(gnt), 32'b0001);

    // 5: owner 3 drops its request
    do_reset();
    step(4'b1000, 4'b1000, 32'h5500_0000, 32'h0);
    check("t5_locked", 32'(locked), 32'd1);
    step(4'b0001, 4'b0000, 32'h0000_00FF, 32'h0);
    check("t5_release", 32'(locked), 32'd0);
    check("t5_q_hold", 32'(q), 32'h55);
    step(4'b0001, 4'b0000, 32'h0000_00FF, 32'h0);
    check("t5_grant0", 32'(q), 32'hFF);

    // 6: asynchronous reset while locked
    do_reset();
    step(4'b0100, 4'b0100, 32'h00AA_0000, 32'h0055_0000);
    check("t6_q", 32'(q), 32'hAA);
    check("t6_locked", 32'(locked), 32'd1);
    #2;
    rst = 1'b0; #1;
    check("t6_async_q", 32'(q), 32'd0);
    check("t6_async_locked", 32'(locked), 32'd0);
    check("t6_async_gnt", 32'(gnt), 32'd0);
    @(posedge Clk); #1;
    rst = 1'b1;
    model_reset();

    // Random traffic with occasional locks
    for (int n = 0; n < 300; n++) begin
      logic [3:0] r, l;
      r = 4'($urandom);
      l = 4'($urandom) & 4'($urandom) & 4'($urandom);
      step(r, l, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
